// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the multicycle-CPU memory bus master.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } mem_state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Clear the byte-offset bits; the bus only ever sees word addresses.
  function automatic logic [63:0] word_align(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Avalon-MM master for a multicycle CPU: turns one-shot fetch/load/store
// requests into bus reads/writes, registers read data onto memdata and
// strobes IRWrite (fetch) / mem_done (any op) for one cycle afterwards.
// Optional MEM_TIMEOUT_EN: abort a transfer after TIMEOUT_CYCLES stalled
// cycles and report it on bus_err.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        byteen_in,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [3:0]        byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] memdata,
  output logic              IRWrite,
  output logic              mem_done,
  output logic              busy
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  mem_state_t state;
  logic       op_fetch;   // finished op was a fetch -> IRWrite in DONE
  logic       req_any;
  logic [ADDR_W-1:0] addr_al;

  assign req_any = fetch_req | load_req | store_req;
  assign addr_al = ADDR_W'(word_align(64'(addr)));

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] stall_cnt;
  logic             err_q;
  logic             expire;
  // The stall that would make the count reach TIMEOUT_CYCLES ends the transfer.
  assign expire = waitrequest && (stall_cnt == CNT_LAST);
`endif

  // FSM plus captured bus request and returned data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      memdata    <= '0;
      op_fetch   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      stall_cnt  <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_any) begin
          address   <= addr_al;
          writedata <= wr_data;
`ifdef MEM_TIMEOUT_EN
          stall_cnt <= '0;
          err_q     <= 1'b0;
`endif
          // Store wins over load over fetch; losers are simply dropped.
          if (store_req) begin
            state      <= STORE;
            byteenable <= byteen_in;
            op_fetch   <= 1'b0;
          end else if (load_req) begin
            state      <= LOAD;
            byteenable <= byteen_in;
            op_fetch   <= 1'b0;
          end else begin
            state      <= FETCH;
            byteenable <= BE_ALL;
            op_fetch   <= 1'b1;
          end
        end
        FETCH, LOAD, STORE: begin
          if (!waitrequest) begin
            if (state != STORE) memdata <= readdata;
            state <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (expire) begin
            state <= DONE;
            err_q <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus strobes and status are pure decodes of the registered state, so an
  // async reset drops them immediately.
  always_comb begin
    read     = (state == FETCH) || (state == LOAD);
    write    = (state == STORE);
    busy     = (state != IDLE);
    mem_done = (state == DONE);
`ifdef MEM_TIMEOUT_EN
    IRWrite  = (state == DONE) && op_fetch && !err_q;
    bus_err  = (state == DONE) && err_q;
`else
    IRWrite  = (state == DONE) && op_fetch;
`endif
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. Inputs change on the falling edge,
// outputs are checked on the falling edge (mid-cycle, after the rising edge).
module tb_mem_access_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, load_req, store_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    byteen_in;
  logic [AW-1:0] address;
  logic          read, write;
  logic [DW-1:0] writedata;
  logic [3:0]    byteenable;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic [DW-1:0] memdata;
  logic          IRWrite, mem_done, busy;
`ifdef MEM_TIMEOUT_EN
  logic          bus_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
    .addr(addr), .wr_data(wr_data), .byteen_in(byteen_in),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .memdata(memdata), .IRWrite(IRWrite), .mem_done(mem_done), .busy(busy)
`ifdef MEM_TIMEOUT_EN
    , .bus_err(bus_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full cycle: through the rising edge to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 64'(busy), 0);
    chk({tag, ".read"}, 64'(read), 0);
    chk({tag, ".write"}, 64'(write), 0);
    chk({tag, ".done"}, 64'(mem_done), 0);
    chk({tag, ".irw"}, 64'(IRWrite), 0);
  endtask

  initial begin
    reset = 1'b1; fetch_req = 0; load_req = 0; store_req = 0;
    addr = '0; wr_data = '0; byteen_in = '0; waitrequest = 0; readdata = '0;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst.addr", 64'(address), 0);
    chk("rst.be", 64'(byteenable), 0);
    chk("rst.mdata", 64'(memdata), 0);
    reset = 1'b0;
    tick();

    // Fetch, zero-wait: offset bits dropped, byteenable forced to all.
    fetch_req = 1; addr = 32'hBFC0_0002; byteen_in = 4'b0001; readdata = 32'h2408_0005;
    tick();
    fetch_req = 0;
    chk("f.read", 64'(read), 1);
    chk("f.addr", 64'(address), 64'h0000_0000_BFC0_0000);
    chk("f.be", 64'(byteenable), 64'hF);
    chk("f.done_early", 64'(mem_done), 0);
    tick();
    chk("f.read_off", 64'(read), 0);
    chk("f.mdata", 64'(memdata), 64'h2408_0005);
    chk("f.irw", 64'(IRWrite), 1);
    chk("f.done", 64'(mem_done), 1);
    readdata = 32'h5555_AAAA;
    tick();
    chk_idle("f.end");
    chk("f.hold", 64'(memdata), 64'h2408_0005);

    // Load with 3 stall cycles; a fetch request while busy must be ignored.
    load_req = 1; addr = 32'h1000_0007; byteen_in = 4'b0101; waitrequest = 1;
    readdata = 32'h0BAD_0BAD;
    tick();
    load_req = 0; fetch_req = 1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("l.rd%0d", i), 64'(read), 1);
      chk($sformatf("l.ad%0d", i), 64'(address), 64'h1000_0004);
      chk($sformatf("l.be%0d", i), 64'(byteenable), 64'h5);
      chk($sformatf("l.md%0d", i), 64'(memdata), 64'h2408_0005);
      tick();
    end
    waitrequest = 0; readdata = 32'hCAFE_F00D; fetch_req = 0;
    chk("l.rd3", 64'(read), 1);
    chk("l.ad3", 64'(address), 64'h1000_0004);
    tick();
    chk("l.done", 64'(mem_done), 1);
    chk("l.irw", 64'(IRWrite), 0);
    chk("l.mdata", 64'(memdata), 64'hCAFE_F00D);
    tick();
    chk_idle("l.end");

    // Store: writedata/byteenable from request, memdata untouched.
    store_req = 1; addr = 32'h0000_0023; wr_data = 32'hDEAD_BEEF; byteen_in = 4'b0011;
    readdata = 32'h1111_1111;
    tick();
    store_req = 0;
    chk("s.write", 64'(write), 1);
    chk("s.read", 64'(read), 0);
    chk("s.addr", 64'(address), 64'h20);
    chk("s.wdata", 64'(writedata), 64'hDEAD_BEEF);
    chk("s.be", 64'(byteenable), 64'h3);
    tick();
    chk("s.done", 64'(mem_done), 1);
    chk("s.irw", 64'(IRWrite), 0);
    chk("s.mdata", 64'(memdata), 64'hCAFE_F00D);
    tick();
    chk_idle("s.end");

    // All three requests together: only the store goes out.
    fetch_req = 1; load_req = 1; store_req = 1;
    addr = 32'h0000_0044; wr_data = 32'h1234_5678; byteen_in = 4'b1100;
    tick();
    fetch_req = 0; load_req = 0; store_req = 0;
    chk("p.write", 64'(write), 1);
    chk("p.read", 64'(read), 0);
    chk("p.be", 64'(byteenable), 64'hC);
    tick();
    chk("p.read2", 64'(read), 0);
    chk("p.done", 64'(mem_done), 1);
    chk("p.irw", 64'(IRWrite), 0);
    tick();
    chk_idle("p.end");

    // Async reset in the middle of a stalled load.
    load_req = 1; addr = 32'h0000_0100; byteen_in = 4'b1111; waitrequest = 1;
    tick();
    load_req = 0;
    tick();
    chk("r.read_pre", 64'(read), 1);
    reset = 1'b1;
    #1;
    chk_idle("r.async");
    chk("r.addr", 64'(address), 0);
    chk("r.mdata", 64'(memdata), 0);
    @(negedge clk);
    reset = 1'b0; waitrequest = 0;
    tick();
    chk_idle("r.after");

`ifdef MEM_TIMEOUT_EN
    // Stuck waitrequest: abort after TO stalled cycles with bus_err.
    fetch_req = 1; addr = 32'h0000_0200; waitrequest = 1; readdata = 32'h7777_7777;
    tick();
    fetch_req = 0;
    for (int i = 0; i < TO; i++) begin
      chk($sformatf("t.rd%0d", i), 64'(read), 1);
      tick();
    end
    chk("t.read_off", 64'(read), 0);
    chk("t.done", 64'(mem_done), 1);
    chk("t.err", 64'(bus_err), 1);
    chk("t.irw", 64'(IRWrite), 0);
    chk("t.mdata", 64'(memdata), 0);
    tick();
    chk_idle("t.end");
    chk("t.err_off", 64'(bus_err), 0);
    waitrequest = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
